// File: rtl/clockport_pkg.sv
// Shared state encodings and default sizing for the clockport latch sequencer.
package clockport_pkg;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_LE_CYCLES   = 2;
    localparam int DEF_ADDR_W      = 4;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_OPEN = 2'd1,
        W_FULL = 2'd2
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_LOAD = 2'd1,
        R_PEND = 2'd2
    } r_state_t;

endpackage

// File: rtl/cp_sync_edge.sv
// N-stage synchroniser for an asynchronous strobe, preset to 1 (inactive),
// with one extra flop behind the last stage for rise/fall detection.
module cp_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_reg;
    logic              prev_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= '1;
            prev_reg <= 1'b1;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], d};
            prev_reg <= sync_reg[STAGES-1];
        end
    end

    assign q    = sync_reg[STAGES-1];
    assign rise = sync_reg[STAGES-1] & ~prev_reg;
    assign fall = ~sync_reg[STAGES-1] & prev_reg;

endmodule

// File: rtl/clockport_latch_seq.sv
// Sequences the Amiga->Pi write latch and Pi->Amiga read latch from
// synchronised clockport strobes; all outputs come straight from flops.
module clockport_latch_seq
    import clockport_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int LE_CYCLES   = DEF_LE_CYCLES,
    parameter int ADDR_W      = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cp_cs_n,
    input  logic              cp_rd_n,
    input  logic              cp_wr_n,
    input  logic [ADDR_W-1:0] cp_addr,
    input  logic              pi_rd,
    input  logic              pi_ack,
    input  logic              pi_load,
    output logic              wr_le,
    output logic              wr_oe_n,
    output logic              rd_le,
    output logic              rd_oe_n,
    output logic              pi_req,
    output logic [ADDR_W-1:0] addr_q,
    output logic              rd_valid,
    output logic              overrun
);

    localparam int            CW       = (LE_CYCLES > 1) ? $clog2(LE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LE_CYCLES - 1);

    // Index 0 = cs, 1 = rd, 2 = wr (all active low)
    logic [2:0] raw_n, q_n, rise_n, fall_n, prev_n;
    assign raw_n = {cp_wr_n, cp_rd_n, cp_cs_n};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            cp_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
                .clk  (clk),
                .rst  (rst),
                .d    (raw_n[gi]),
                .q    (q_n[gi]),
                .rise (rise_n[gi]),
                .fall (fall_n[gi])
            );
        end
    endgenerate

    // Any edge on a line means the delayed flop holds the opposite level.
    assign prev_n = q_n ^ (rise_n | fall_n);

    logic wr_s, rd_s, wr_p, rd_p, wr_eff, rd_eff, wr_eff_p, rd_eff_p, wr_rise, rd_fall;
    assign wr_s     = ~q_n[0] & ~q_n[2];
    assign rd_s     = ~q_n[0] & ~q_n[1];
    assign wr_p     = ~prev_n[0] & ~prev_n[2];
    assign rd_p     = ~prev_n[0] & ~prev_n[1];
    // Simultaneous read and write is treated as no access on either path.
    assign wr_eff   = wr_s & ~rd_s;
    assign rd_eff   = rd_s & ~wr_s;
    assign wr_eff_p = wr_p & ~rd_p;
    assign rd_eff_p = rd_p & ~wr_p;
    assign wr_rise  = wr_eff & ~wr_eff_p;
    assign rd_fall  = ~rd_eff & rd_eff_p;

    w_state_t          w_state_reg, w_state_next;
    logic [CW-1:0]     w_cnt_reg, w_cnt_next;
    logic              wr_le_reg, wr_le_next, wr_oe_n_reg, wr_oe_n_next;
    logic              pi_req_reg, pi_req_next, overrun_reg, overrun_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    r_state_t          r_state_reg, r_state_next;
    logic [CW-1:0]     r_cnt_reg, r_cnt_next;
    logic              rd_le_reg, rd_le_next, rd_oe_n_reg, rd_oe_n_next;
    logic              rd_valid_reg, rd_valid_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_reg  <= W_IDLE;
            w_cnt_reg    <= '0;
            wr_le_reg    <= 1'b0;
            wr_oe_n_reg  <= 1'b1;
            pi_req_reg   <= 1'b0;
            overrun_reg  <= 1'b0;
            addr_reg     <= '0;
            r_state_reg  <= R_IDLE;
            r_cnt_reg    <= '0;
            rd_le_reg    <= 1'b0;
            rd_oe_n_reg  <= 1'b1;
            rd_valid_reg <= 1'b0;
        end else begin
            w_state_reg  <= w_state_next;
            w_cnt_reg    <= w_cnt_next;
            wr_le_reg    <= wr_le_next;
            wr_oe_n_reg  <= wr_oe_n_next;
            pi_req_reg   <= pi_req_next;
            overrun_reg  <= overrun_next;
            addr_reg     <= addr_next;
            r_state_reg  <= r_state_next;
            r_cnt_reg    <= r_cnt_next;
            rd_le_reg    <= rd_le_next;
            rd_oe_n_reg  <= rd_oe_n_next;
            rd_valid_reg <= rd_valid_next;
        end
    end

    always_comb begin
        w_state_next = w_state_reg;
        w_cnt_next   = w_cnt_reg;
        wr_le_next   = wr_le_reg;
        wr_oe_n_next = wr_oe_n_reg;
        pi_req_next  = pi_req_reg;
        addr_next    = addr_reg;
        overrun_next = overrun_reg | (wr_rise & (w_state_reg != W_IDLE));
        case (w_state_reg)
            W_IDLE: begin
                if (wr_rise && !pi_req_reg) begin
                    w_state_next = W_OPEN;
                    w_cnt_next   = '0;
                    wr_le_next   = 1'b1;
                    addr_next    = cp_addr;
                end
            end
            W_OPEN: begin
                if (w_cnt_reg == CNT_LAST) begin
                    wr_le_next   = 1'b0;
                    pi_req_next  = 1'b1;
                    w_state_next = W_FULL;
                end else begin
                    w_cnt_next = w_cnt_reg + 1'b1;
                end
            end
            W_FULL: begin
                if (pi_ack) begin
                    pi_req_next  = 1'b0;
                    wr_oe_n_next = 1'b1;
                    w_state_next = W_IDLE;
                end else begin
                    wr_oe_n_next = ~pi_rd;
                end
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_next  = r_state_reg;
        r_cnt_next    = r_cnt_reg;
        rd_le_next    = rd_le_reg;
        rd_oe_n_next  = ~rd_eff;
        rd_valid_next = rd_fall ? 1'b0 : rd_valid_reg;
        case (r_state_reg)
            R_IDLE: begin
                if (pi_load) begin
                    if (rd_s) begin
                        r_state_next = R_PEND;
                    end else begin
                        r_state_next = R_LOAD;
                        r_cnt_next   = '0;
                        rd_le_next   = 1'b1;
                    end
                end
            end
            R_LOAD: begin
                if (r_cnt_reg == CNT_LAST) begin
                    rd_le_next    = 1'b0;
                    rd_valid_next = 1'b1;
                    r_state_next  = R_IDLE;
                end else begin
                    r_cnt_next = r_cnt_reg + 1'b1;
                end
            end
            R_PEND: begin
                // Hold off the load until the Amiga has released the bus.
                if (!rd_s) begin
                    r_state_next = R_LOAD;
                    r_cnt_next   = '0;
                    rd_le_next   = 1'b1;
                end
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    assign wr_le    = wr_le_reg;
    assign wr_oe_n  = wr_oe_n_reg;
    assign rd_le    = rd_le_reg;
    assign rd_oe_n  = rd_oe_n_reg;
    assign pi_req   = pi_req_reg;
    assign addr_q   = addr_reg;
    assign rd_valid = rd_valid_reg;
    assign overrun  = overrun_reg;

endmodule

// File: tb/tb_clockport_latch_seq.sv
// Directed bench for clockport_latch_seq with hand-computed cycle expectations.
module tb_clockport_latch_seq;

    logic       clk = 1'b0;
    logic       rst, cp_cs_n, cp_rd_n, cp_wr_n, pi_rd, pi_ack, pi_load;
    logic [3:0] cp_addr;
    logic       wr_le, wr_oe_n, rd_le, rd_oe_n, pi_req, rd_valid, overrun;
    logic [3:0] addr_q;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clockport_latch_seq #(.SYNC_STAGES(2), .LE_CYCLES(2), .ADDR_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .cp_cs_n  (cp_cs_n),
        .cp_rd_n  (cp_rd_n),
        .cp_wr_n  (cp_wr_n),
        .cp_addr  (cp_addr),
        .pi_rd    (pi_rd),
        .pi_ack   (pi_ack),
        .pi_load  (pi_load),
        .wr_le    (wr_le),
        .wr_oe_n  (wr_oe_n),
        .rd_le    (rd_le),
        .rd_oe_n  (rd_oe_n),
        .pi_req   (pi_req),
        .addr_q   (addr_q),
        .rd_valid (rd_valid),
        .overrun  (overrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance n clocks; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold a strobe combination for hold clocks, release, let it settle; count activity.
    task automatic access(input logic rd_n, input logic wr_n, input logic [3:0] a, input int hold,
                          output int wle, output int rle, output int roe);
        wle = 0; rle = 0; roe = 0;
        cp_addr = a; cp_cs_n = 1'b0; cp_rd_n = rd_n; cp_wr_n = wr_n;
        for (int i = 0; i < hold + 6; i++) begin
            if (i == hold) begin
                cp_cs_n = 1'b1; cp_rd_n = 1'b1; cp_wr_n = 1'b1;
            end
            tick(1);
            wle += int'(wr_le);
            rle += int'(rd_le);
            roe += int'(!rd_oe_n);
        end
        $display("access rd_n=%0b wr_n=%0b addr=%0h hold=%0d: wr_le=%0d rd_le=%0d rd_oe=%0d cycles",
                 rd_n, wr_n, a, hold, wle, rle, roe);
    endtask

    task automatic pulse_load();
        pi_load = 1'b1;
        tick(1);
        pi_load = 1'b0;
    endtask

    initial begin
        int wle, rle, roe;
        rst = 1'b1; cp_cs_n = 1'b1; cp_rd_n = 1'b1; cp_wr_n = 1'b1; cp_addr = 4'h0;
        pi_rd = 1'b0; pi_ack = 1'b0; pi_load = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(3);
        $display("reset/idle");
        check("rst_wr_le", wr_le, 0);     check("rst_rd_le", rd_le, 0);
        check("rst_wr_oe_n", wr_oe_n, 1); check("rst_rd_oe_n", rd_oe_n, 1);
        check("rst_pi_req", pi_req, 0);   check("rst_rd_valid", rd_valid, 0);
        check("rst_overrun", overrun, 0); check("rst_addr_q", addr_q, 0);

        // Write at addr A, held 10 clocks: LE high on clocks 3 and 4.
        $display("write addr=A");
        cp_addr = 4'hA; cp_cs_n = 1'b0; cp_wr_n = 1'b0;
        tick(2); check("w_le_c2", wr_le, 0);
        tick(1); check("w_le_c3", wr_le, 1); check("w_addr", addr_q, 4'hA);
        tick(1); check("w_le_c4", wr_le, 1); check("w_req_c4", pi_req, 0);
        tick(1); check("w_le_c5", wr_le, 0); check("w_req_c5", pi_req, 1);
        tick(5);
        cp_cs_n = 1'b1; cp_wr_n = 1'b1;
        tick(4);
        check("w_le_after", wr_le, 0); check("w_oe_idle", wr_oe_n, 1);

        $display("pi read + ack");
        pi_rd = 1'b1;
        tick(1); check("pirdoe_c1", wr_oe_n, 0);
        tick(2); check("pirdoe_c3", wr_oe_n, 0);
        pi_rd = 1'b0; pi_ack = 1'b1;
        tick(1); pi_ack = 1'b0;
        check("ack_oe", wr_oe_n, 1); check("ack_req", pi_req, 0); check("ack_ovr", overrun, 0);
        pi_ack = 1'b1; tick(1); pi_ack = 1'b0;
        check("stray_ack_req", pi_req, 0);

        // Overrun: accepted write, then a second one before ack.
        access(1'b1, 1'b0, 4'h5, 4, wle, rle, roe);
        check("w2_le_cnt", wle, 2); check("w2_req", pi_req, 1); check("w2_addr", addr_q, 4'h5);
        access(1'b1, 1'b0, 4'h3, 4, wle, rle, roe);
        check("ovr_le_cnt", wle, 0); check("ovr_flag", overrun, 1); check("ovr_addr", addr_q, 4'h5);
        pi_ack = 1'b1; tick(1); pi_ack = 1'b0;
        tick(2);
        check("ovr_ack_req", pi_req, 0); check("ovr_sticky", overrun, 1);

        // Reset in the middle of W_OPEN.
        $display("reset during W_OPEN");
        cp_addr = 4'h7; cp_cs_n = 1'b0; cp_wr_n = 1'b0;
        tick(3); check("rs_le_open", wr_le, 1);
        rst = 1'b1;
        tick(1); check("rs_le_abort", wr_le, 0); check("rs_ovr_clr", overrun, 0);
        cp_cs_n = 1'b1; cp_wr_n = 1'b1;
        tick(3); rst = 1'b0; tick(3);
        check("rs_req", pi_req, 0); check("rs_addr", addr_q, 0);

        // Idle pi_load then an Amiga read of 6 clocks.
        $display("pi_load idle");
        pulse_load();
        check("ld_le_c1", rd_le, 1); check("ld_val_c1", rd_valid, 0);
        tick(1); check("ld_le_c2", rd_le, 1);
        tick(1); check("ld_le_c3", rd_le, 0); check("ld_val_c3", rd_valid, 1);
        $display("amiga read 6 clks");
        cp_cs_n = 1'b0; cp_rd_n = 1'b0;
        tick(2); check("rd_oe_c2", rd_oe_n, 1);
        tick(1); check("rd_oe_c3", rd_oe_n, 0);
        tick(3); check("rd_val_hold", rd_valid, 1);
        cp_cs_n = 1'b1; cp_rd_n = 1'b1;
        tick(2); check("rdrel_oe_c2", rd_oe_n, 0); check("rdrel_val_c2", rd_valid, 1);
        tick(1); check("rdrel_oe_c3", rd_oe_n, 1); check("rdrel_val_c3", rd_valid, 0);

        // Pending load under an active read.
        $display("pi_load during amiga read");
        pulse_load(); tick(2);
        check("pd_pre_val", rd_valid, 1);
        cp_cs_n = 1'b0; cp_rd_n = 1'b0;
        tick(4);
        pulse_load();
        check("pd_le_c1", rd_le, 0);
        tick(3); check("pd_le_c4", rd_le, 0); check("pd_val_hold", rd_valid, 1);
        cp_cs_n = 1'b1; cp_rd_n = 1'b1;
        tick(2); check("pdrel_le_c2", rd_le, 0);
        tick(1); check("pdrel_le_c3", rd_le, 1); check("pdrel_val_c3", rd_valid, 0);
        tick(1); check("pdrel_le_c4", rd_le, 1);
        tick(1); check("pdrel_le_c5", rd_le, 0); check("pdrel_val_c5", rd_valid, 1);

        // rd and wr together: nothing should move.
        access(1'b0, 1'b0, 4'hC, 6, wle, rle, roe);
        check("both_wle", wle, 0); check("both_rle", rle, 0); check("both_roe", roe, 0);
        check("both_req", pi_req, 0); check("both_ovr", overrun, 0);
        check("both_val", rd_valid, 1); check("both_addr", addr_q, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
